clk_gate_ctrl: RTL
==================

// Module: clk_gate_ctrl
// PURPOSE
//  Multi-channel clock-gating controller; successor to the single-enable gate cell.
//  Each of NUM_CH domains gets a glitch-free gated clock, a request/ack wake handshake,
//  a programmable wake settle time and an idle-timeout auto-gate.
//  Sits at the system clock root, feeding gated clocks to ALU/RegFile/UART-style sub-blocks.
// PARAMETERS
//  NUM_CH    4  number of independent gated-clock channels (1..16)
//  WAKE_CYC  2  gated-clock cycles run before CH_ACK asserts (0..255)
//  IDLE_CYC  8  idle cycles (REQ=0 & BUSY=0) tolerated before the channel gates off (0..255)
//  POST_SYN  0  0 = behavioural latch+AND cell; 1 = library ICG cell instance
// PORTS
//  CLK        in   1       system clock (ungated source)
//  RST        in   1       async reset, active low
//  TEST_EN    in   1       scan/test override: forces all gated clocks on
//  CH_REQ     in   NUM_CH  per-channel clock request (level)
//  CH_BUSY    in   NUM_CH  per-channel activity flag; holds clock on while high
//  CH_ACK     out  NUM_CH  channel clock running and settled
//  GATED_CLK  out  NUM_CH  gated clocks
//  ALL_IDLE   out  1       all channels in OFF
// BEHAVIOUR
//  Reset (RST=0, async): every FSM -> OFF, counters=0, CH_ACK=0, ALL_IDLE=1, enable regs=0.
//   Hold RST low for >=1 full CLK period so every enable latch captures 0 (GATED_CLK low).
//   Reset mid-operation: CH_ACK drops immediately; gated clocks stop at the next CLK low phase.
//  Per-channel FSM (registered on posedge CLK), en = clock enable into the cell:
//   OFF   en=0 ACK=0. CH_REQ=1 -> WAKE, cnt<=WAKE_CYC. BUSY alone does not wake.
//   WAKE  en=1 ACK=0. cnt!=0: cnt-1. cnt==0 -> ON. WAKE is never aborted; REQ drop ignored.
//         WAKE_CYC=0: exactly one WAKE cycle.
//   ON    en=1 ACK=1. REQ=0 & BUSY=0 -> DRAIN, cnt<=IDLE_CYC; otherwise stay.
//   DRAIN en=1 ACK=1. REQ|BUSY -> ON (cnt discarded). Else cnt!=0: cnt-1; cnt==0 -> OFF.
//         IDLE_CYC=0: exactly one DRAIN cycle.
//  Latency: REQ sampled high at edge N -> WAKE after N; first GATED_CLK rising edge at N+1;
//   CH_ACK high after edge N+1+WAKE_CYC. Leaving DRAIN at edge M -> last gated pulse at M.
//  Gating: cell latch is transparent while CLK low. Input = en | TEST_EN.
//   GATED_CLK = CLK & latched. No truncated or glitched pulses. TEST_EN changes apply at the
//   next CLK low phase; FSMs, counters and ACK are unaffected by TEST_EN.
//  ALL_IDLE: registered; 1 on the edge after all FSMs are in OFF. Channels fully independent.
//  Counter width: CNT_W = clog2(max(WAKE_CYC,IDLE_CYC)+1); decrement never wraps below 0.
//  State encoding: OFF=2'b00, WAKE=2'b01, ON=2'b10, DRAIN=2'b11 (one-hot not required).
// STRUCTURE
//  clk_gate_pkg: state encodings, CNT_W function (clog2/max), parameter range checks.
//  Sub-module clk_gate_cell (POST_SYN param): negative-level latch + AND for simulation,
//   library integrated-clock-gate cell for synthesis; one instance per channel via generate.
//  Top: generate loop of per-channel FSM + counter + ACK register; ALL_IDLE reduction register.
// TESTING
//  1 Reset: RST=0 for 3 CLK cycles, REQ=4'hF -> ACK=0, GATED_CLK flat 0, ALL_IDLE=1.
//  2 Wake: WAKE_CYC=2, REQ[0] rises before edge 10 -> first GATED_CLK[0] pulse at edge 11,
//    ACK[0] high after edge 13; other channels stay flat.
//  3 Idle timeout: IDLE_CYC=8, REQ[1]=BUSY[1]=0 from ON at edge 20 -> DRAIN,
//    last pulse at edge 29, ACK[1]=0 after 29. BUSY[1] pulse at edge 25 -> back to ON.
//  4 Boundary: WAKE_CYC=0, IDLE_CYC=0; 1-cycle REQ pulse -> OFF>WAKE>ON>DRAIN>OFF,
//    exactly 3 gated pulses; no glitch when REQ toggles mid-high-phase.
//  5 Test override: TEST_EN=1 with all REQ=0 -> all GATED_CLK toggle, ACK=0, ALL_IDLE=1.
//  6 Async reset mid-ON on ch0-3 -> ACK drops same instant; no clock pulse narrower than CLK high.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and elaboration helpers for the multi-channel clock-gating controller.
// Holds the per-channel state encoding, the counter-width function and the parameter range check.
package clk_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_WAKE  = 2'b01,
      ST_ON    = 2'b10,
      ST_DRAIN = 2'b11
   } ch_state_e;

   localparam int MAX_CH  = 16;
   localparam int MAX_CYC = 255;

   // Wide enough for the larger of the two settle/idle reload values; never narrower than 1 bit.
   function automatic int cnt_w(input int wake_cyc, input int idle_cyc);
      int m;
      m = (wake_cyc > idle_cyc) ? wake_cyc : idle_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

   function automatic bit params_ok(input int num_ch, input int wake_cyc,
                                    input int idle_cyc, input int post_syn);
      return (num_ch >= 1) && (num_ch <= MAX_CH) &&
             (wake_cyc >= 0) && (wake_cyc <= MAX_CYC) &&
             (idle_cyc >= 0) && (idle_cyc <= MAX_CYC) &&
             (post_syn == 0 || post_syn == 1);
   endfunction

endpackage

// File: rtl/clk_gate_ctrl_cell.sv
// Glitch-free clock gate: enable is captured by a latch that is transparent while clk is low,
// so the gated output only ever produces full-width clk high phases.
module clk_gate_ctrl_cell #(
   parameter int POST_SYN = 0
) (
   input  logic clk,
   input  logic en,
   input  logic test_en,
   output logic gclk
);

   logic en_lat;

   if (POST_SYN == 0) begin : g_beh
      always_latch begin
         if (!clk) en_lat <= en | test_en;
      end
   end else begin : g_icg
      // ICG-style pin order: the test enable bypasses the functional enable ahead of the latch.
      logic en_mux;
      assign en_mux = test_en ? 1'b1 : en;
      always_latch begin
         if (!clk) en_lat <= en_mux;
      end
   end

   assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel wake/settle/idle-timeout FSM driving
// a glitch-free gate cell, plus a registered all-channels-idle flag.
module clk_gate_ctrl
   import clk_gate_ctrl_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WAKE_CYC = 2,
   parameter int IDLE_CYC = 8,
   parameter int POST_SYN = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                test_en,
   input  logic [NUM_CH-1:0]   ch_req,
   input  logic [NUM_CH-1:0]   ch_busy,
   output logic [NUM_CH-1:0]   ch_ack,
   output logic [NUM_CH-1:0]   gated_clk,
   output logic                all_idle,
   output logic [2*NUM_CH-1:0] dbg_state
);

   localparam int CNT_W = cnt_w(WAKE_CYC, IDLE_CYC);
   localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC);
   localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_CH-1:0] ch_off;

   if (!params_ok(NUM_CH, WAKE_CYC, IDLE_CYC, POST_SYN)) begin : g_param_err
      $error("clk_gate_ctrl: parameter out of range");
   end

   // Handshake: ch_req is a level; ch_ack rises once the gated clock has run WAKE_CYC settle
   // cycles and stays high until the idle timeout expires, so a requester may only rely on its
   // clock while ch_ack is high. ch_busy extends the clock but never starts it.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_e        state;
      logic [CNT_W-1:0] cnt;
      logic             en;
      logic             ack;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= ST_OFF;
            cnt   <= '0;
            en    <= 1'b0;
            ack   <= 1'b0;
         end else begin
            case (state)
               ST_OFF: begin
                  if (ch_req[i]) begin
                     state <= ST_WAKE;
                     cnt   <= WAKE_LD;
                     en    <= 1'b1;
                  end
               end
               ST_WAKE: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_ONE;
                  end else begin
                     state <= ST_ON;
                     ack   <= 1'b1;
                  end
               end
               ST_ON: begin
                  if (!ch_req[i] && !ch_busy[i]) begin
                     state <= ST_DRAIN;
                     cnt   <= IDLE_LD;
                  end
               end
               ST_DRAIN: begin
                  if (ch_req[i] || ch_busy[i]) begin
                     state <= ST_ON;
                  end else if (cnt != '0) begin
                     cnt <= cnt - CNT_ONE;
                  end else begin
                     state <= ST_OFF;
                     en    <= 1'b0;
                     ack   <= 1'b0;
                  end
               end
               default: begin
                  state <= ST_OFF;
                  cnt   <= '0;
                  en    <= 1'b0;
                  ack   <= 1'b0;
               end
            endcase
         end
      end

      assign ch_ack[i]           = ack;
      assign ch_off[i]           = (state == ST_OFF);
      assign dbg_state[2*i +: 2] = state;

      clk_gate_ctrl_cell #(.POST_SYN(POST_SYN)) u_cell (
         .clk     (clk),
         .en      (en),
         .test_en (test_en),
         .gclk    (gated_clk[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) all_idle <= 1'b1;
      else        all_idle <= &ch_off;
   end

endmodule
